// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: opcodes, cmd_flags bit positions and driver FSM states.
package alsu_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MUL    = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_INV6   = 3'd6,
        OP_INV7   = 3'd7
    } alsu_opcode_e;

    localparam int FLAG_RED_OP_A = 6;
    localparam int FLAG_RED_OP_B = 5;
    localparam int FLAG_BYPASS_A = 4;
    localparam int FLAG_BYPASS_B = 3;
    localparam int FLAG_DIR      = 2;
    localparam int FLAG_SERIAL   = 1;
    localparam int FLAG_CIN      = 0;

    typedef logic [1:0] drv_state_t;
    localparam drv_state_t ST_IDLE = 2'd0;
    localparam drv_state_t ST_WAIT = 2'd1;
    localparam drv_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alsu_inv_check.sv
// Combinational predictor of commands the ALSU treats as invalid (result forced to 0).
module alsu_inv_check
    import alsu_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic       red_op_a,
    input  logic       red_op_b,
    input  logic       bypass_a,
    input  logic       bypass_b,
    output logic       invalid
);

    // Bypass takes precedence inside the ALSU, so a bypassed command is never invalid.
    assign invalid = !bypass_a && !bypass_b &&
                     ((opcode >= OP_INV6) || ((red_op_a || red_op_b) && (opcode >= OP_ADD)));

endmodule

// File: rtl/alsu_cmd_driver.sv
// Valid/ready command-to-pin driver for the ALSU; captures out after LATENCY cycles.
// Optional invalid-command checker enabled by defining ALSU_DRV_CHECK_EN.
module alsu_cmd_driver
    import alsu_pkg::*;
#(
    parameter int LATENCY = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_opcode,
    input  logic [2:0] cmd_a,
    input  logic [2:0] cmd_b,
    input  logic [6:0] cmd_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [5:0] rsp_data,
    output logic       rsp_invalid,
    output logic       rsp_err,
    output logic       busy,
    output logic [2:0] alsu_a,
    output logic [2:0] alsu_b,
    output logic [2:0] alsu_opcode,
    output logic       alsu_cin,
    output logic       alsu_serial_in,
    output logic       alsu_direction,
    output logic       alsu_red_op_a,
    output logic       alsu_red_op_b,
    output logic       alsu_bypass_a,
    output logic       alsu_bypass_b,
    input  logic [5:0] alsu_out
);

    drv_state_t state_reg;
    logic [3:0] cnt_reg;
    logic       cmd_ready_reg;
    logic       rsp_valid_reg;
    logic [5:0] rsp_data_reg;
    logic [2:0] a_reg;
    logic [2:0] b_reg;
    logic [2:0] opcode_reg;
    logic [6:0] flags_reg;
    logic       accept;
    logic       capture;

    assign accept  = (state_reg == ST_IDLE) && cmd_ready_reg && cmd_valid;
    assign capture = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);

    // cmd_ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 6'd0;
            a_reg         <= 3'd0;
            b_reg         <= 3'd0;
            opcode_reg    <= 3'd0;
            flags_reg     <= 7'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= ST_WAIT;
                        cmd_ready_reg <= 1'b0;
                        cnt_reg       <= 4'(LATENCY);
                        a_reg         <= cmd_a;
                        b_reg         <= cmd_b;
                        opcode_reg    <= cmd_opcode;
                        flags_reg     <= cmd_flags;
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (capture) begin
                        rsp_data_reg  <= alsu_out;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;
    assign alsu_a         = a_reg;
    assign alsu_b         = b_reg;
    assign alsu_opcode    = opcode_reg;
    assign alsu_red_op_a  = flags_reg[FLAG_RED_OP_A];
    assign alsu_red_op_b  = flags_reg[FLAG_RED_OP_B];
    assign alsu_bypass_a  = flags_reg[FLAG_BYPASS_A];
    assign alsu_bypass_b  = flags_reg[FLAG_BYPASS_B];
    assign alsu_direction = flags_reg[FLAG_DIR];
    assign alsu_serial_in = flags_reg[FLAG_SERIAL];
    assign alsu_cin       = flags_reg[FLAG_CIN];

`ifdef ALSU_DRV_CHECK_EN
    logic inv_pred;
    logic inv_reg;
    logic err_reg;

    alsu_inv_check u_inv_check (
        .opcode   (cmd_opcode),
        .red_op_a (cmd_flags[FLAG_RED_OP_A]),
        .red_op_b (cmd_flags[FLAG_RED_OP_B]),
        .bypass_a (cmd_flags[FLAG_BYPASS_A]),
        .bypass_b (cmd_flags[FLAG_BYPASS_B]),
        .invalid  (inv_pred)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_reg <= 1'b0;
            err_reg <= 1'b0;
        end else if (accept) begin
            inv_reg <= inv_pred;
            err_reg <= 1'b0;
        end else if (capture) begin
            err_reg <= inv_reg && (alsu_out != 6'd0);
        end
    end

    assign rsp_invalid = inv_reg;
    assign rsp_err     = err_reg;
`else
    assign rsp_invalid = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: doc/alsu_cmd_driver.md
# alsu_cmd_driver

Command-side initiator for the ALSU. It accepts one operation at a time on a valid/ready command port and drives the ALSU input pins with it. It waits out the ALSU's fixed pipeline latency, captures `out`, and returns the result on a valid/ready response port. It sits between a host or sequencer and the ALSU instance, replacing free-running pin wiggling with a transaction interface.

## Interface
- `LATENCY`, default 2: ALSU cycles from pin change to result register. Legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: driver can accept a command. High only in IDLE.
- `cmd_opcode` in 3: ALSU opcode.
- `cmd_a`, `cmd_b` in 3: operands.
- `cmd_flags` in 7: bits are [6] red_op_A, [5] red_op_B, [4] bypass_A, [3] bypass_B, [2] direction, [1] serial_in, [0] cin.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out 6: captured ALSU `out`.
- `rsp_invalid` out 1: command predicted invalid. Macro-dependent.
- `rsp_err` out 1: invalid command but ALSU `out` was not 0. Macro-dependent.
- `busy` out 1: state is not IDLE.
- `alsu_a`, `alsu_b`, `alsu_opcode` out 3: driven to the ALSU.
- `alsu_cin`, `alsu_serial_in`, `alsu_direction`, `alsu_red_op_a`, `alsu_red_op_b`, `alsu_bypass_a`, `alsu_bypass_b` out 1: driven to the ALSU.
- `alsu_out` in 6: ALSU result.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE to WAIT on `cmd_valid && cmd_ready` (edge T). At T, all alsu_* pins load from the command and the counter loads LATENCY.
  - WAIT: the counter decrements each edge. When the counter is 0, `rsp_data` is captured from `alsu_out`, `rsp_valid` is set, and the FSM moves to RESP.
  - RESP to IDLE on `rsp_valid && rsp_ready`. `rsp_valid` clears on that edge.
- The alsu_* pins hold the last command in every state.
  - Shift and rotate keep advancing inside the ALSU between commands. That is the ALSU's behaviour, and the driver does not mask it.
- `rsp_data` is stable while `rsp_valid && !rsp_ready`.
- `cmd_ready` is a function of state only. It does not depend on `cmd_valid`.
- A command offered while busy is not accepted; the producer holds it.
- Widths: the counter is 4 bits. There is no arithmetic on data; the driver only captures it.

## Timing
- Reset values: `cmd_ready`=0 during reset; all alsu_* pins=0; `rsp_valid`=0; `rsp_data`=0; `rsp_invalid`=0; `rsp_err`=0; `busy`=0; counter=0; state=IDLE.
  - `cmd_ready`=1 from the first edge after `rst` deasserts.
- Latency: command accepted at edge T gives `rsp_valid`=1 after edge T+LATENCY+1. With the default, that is T+3: ALSU input registers at T+1, output register at T+2, capture at T+3.
- Throughput with `rsp_ready` tied high: response handshake at T+LATENCY+2, next command accepted no earlier than T+LATENCY+3.
- Reset mid-operation (WAIT or RESP):
  - The command is discarded with no response.
  - All outputs return to their reset values on the reset edge.
  - The ALSU is not reset by this block.
- Simultaneous `rst` and handshake: reset wins.

## Configuration
- `ALSU_DRV_CHECK_EN` defined:
  - At accept, `rsp_invalid` is computed as `!bypass_A && !bypass_B && (opcode>=6 || ((red_op_A||red_op_B) && opcode>=2))`.
  - At capture, `rsp_err = rsp_invalid && (alsu_out != 0)`.
  - Both flags are held with `rsp_data`.
- `ALSU_DRV_CHECK_EN` undefined: `rsp_invalid` and `rsp_err` are tied 0, and no checker logic is synthesised.

## Structure
- Shared package `alsu_pkg`:
  - Opcode enum: OP_AND=0, OP_XOR=1, OP_ADD=2, OP_MUL=3, OP_SHIFT=4, OP_ROTATE=5, OP_INV6=6, OP_INV7=7.
  - `cmd_flags` bit-index constants.
  - FSM state enum.
- Sub-module `alsu_inv_check`: combinational invalid predictor, instantiated only under `ALSU_DRV_CHECK_EN`.

## Test plan
Bench: LATENCY=2; ALSU instance with INPUT_PRIORITY "A", FULL_ADDER "ON"; `rsp_ready`=1 unless stated.
- AND: A=3'b101, B=3'b110, op=0, flags=0 -> `rsp_data`=6'b000100, `rsp_valid` after accept edge +3.
- ADD/MUL: A=7, B=7, op=2, cin=1 -> `rsp_data`=6'd15. Then A=7, B=5, op=3 -> `rsp_data`=6'd35.
- Invalid: op=6, A=3, B=3 -> `rsp_data`=0; with macro, `rsp_invalid`=1 and `rsp_err`=0. Also red_op_A=1 with op=3 -> same result.
- Backpressure: `rsp_ready`=0 for 5 cycles -> `rsp_valid` and `rsp_data` stable, `cmd_ready`=0, a second pending command not accepted until the cycle after the response handshake.
- Reset in WAIT: `rst`=1 for one cycle -> all outputs at reset values on the next edge, no response, `cmd_ready`=1 the edge after `rst` falls.
